// File: rtl/qsys_clkdiv_multi.sv
// Multi-channel programmable clock divider with a settle/lock supervisor.
// Optional CLKGEN_SYNC_PULSE_EN adds sync_pulse, which marks cycles where all enabled channels sit at count 0.
module qsys_clkdiv_multi #(
  parameter int NUM_CLOCKS  = 4,
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 4,
  parameter int LOCK_CYCLES = 256
) (
  input  logic                  refclk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [2:0]            cfg_chan,
  input  logic [DIV_W-1:0]      cfg_div,
  input  logic [DIV_W-1:0]      cfg_phase,
  output logic [NUM_CLOCKS-1:0] outclk,
  output logic [NUM_CLOCKS-1:0] outclk_en,
`ifdef CLKGEN_SYNC_PULSE_EN
  output logic                  sync_pulse,
`endif
  output logic                  locked
);

  localparam int SET_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(LOCK_CYCLES - 1);

  typedef enum logic {ST_SETTLE = 1'b0, ST_LOCKED = 1'b1} state_t;

  state_t                  r_state;
  logic [SET_W-1:0]        r_settle;
  logic                    r_locked;
  logic                    r_ready;
  logic [NUM_CLOCKS-1:0]   r_clk;
  logic [NUM_CLOCKS-1:0]   r_pen;
  logic [DIV_W-1:0]        r_div   [NUM_CLOCKS];
  logic [DIV_W-1:0]        r_phase [NUM_CLOCKS];
  logic [DIV_W-1:0]        r_cnt   [NUM_CLOCKS];

  logic                    w_hit;
  logic                    w_lock_nxt;
  logic [DIV_W-1:0]        w_div_nxt   [NUM_CLOCKS];
  logic [DIV_W-1:0]        w_phase_nxt [NUM_CLOCKS];
  logic [DIV_W-1:0]        w_cnt_nxt   [NUM_CLOCKS];
  logic [NUM_CLOCKS-1:0]   w_en_nxt;
  logic [NUM_CLOCKS-1:0]   w_clk_nxt;
  logic [NUM_CLOCKS-1:0]   w_pen_nxt;

  function automatic logic [DIV_W-1:0] clamp_phase(input logic [DIV_W-1:0] p,
                                                   input logic [DIV_W-1:0] d);
    return (p >= d) ? '0 : p;
  endfunction

  // Caller guarantees d >= 2, so d-1 never underflows.
  function automatic logic [DIV_W-1:0] next_count(input logic [DIV_W-1:0] c,
                                                  input logic [DIV_W-1:0] d);
    return (c >= d - DIV_W'(1)) ? '0 : c + DIV_W'(1);
  endfunction

  assign w_hit      = cfg_valid && r_ready && (int'(cfg_chan) < NUM_CLOCKS);
  assign w_lock_nxt = (r_state == ST_SETTLE) ? (r_settle == SET_LAST) : !w_hit;

  always_comb begin
    for (int i = 0; i < NUM_CLOCKS; i++) begin
      w_div_nxt[i]   = r_div[i];
      w_phase_nxt[i] = r_phase[i];
      if (w_hit && (int'(cfg_chan) == i)) begin
        w_div_nxt[i]   = cfg_div;
        w_phase_nxt[i] = clamp_phase(cfg_phase, cfg_div);
      end
      w_en_nxt[i] = (w_div_nxt[i] >= DIV_W'(2));
      // An accepted config restarts every channel at its phase to keep them aligned.
      if (!w_en_nxt[i])
        w_cnt_nxt[i] = '0;
      else if (w_hit)
        w_cnt_nxt[i] = w_phase_nxt[i];
      else
        w_cnt_nxt[i] = next_count(r_cnt[i], r_div[i]);
      w_clk_nxt[i] = w_en_nxt[i] && (w_cnt_nxt[i] < (w_div_nxt[i] >> 1));
      w_pen_nxt[i] = w_en_nxt[i] && (w_cnt_nxt[i] == '0);
    end
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_SETTLE;
      r_settle <= '0;
      r_locked <= 1'b0;
      r_ready  <= 1'b0;
      r_clk    <= '0;
      r_pen    <= '0;
      for (int i = 0; i < NUM_CLOCKS; i++) begin
        r_div[i]   <= DIV_W'(DEFAULT_DIV);
        r_phase[i] <= '0;
        r_cnt[i]   <= '0;
      end
    end else begin
      r_locked <= w_lock_nxt;
      r_ready  <= w_lock_nxt;
      r_clk    <= w_clk_nxt;
      r_pen    <= w_pen_nxt;
      for (int i = 0; i < NUM_CLOCKS; i++) begin
        r_div[i]   <= w_div_nxt[i];
        r_phase[i] <= w_phase_nxt[i];
        r_cnt[i]   <= w_cnt_nxt[i];
      end
      case (r_state)
        ST_SETTLE: begin
          if (r_settle == SET_LAST)
            r_state <= ST_LOCKED;
          else
            r_settle <= r_settle + SET_W'(1);
        end
        ST_LOCKED: begin
          if (w_hit) begin
            r_state  <= ST_SETTLE;
            r_settle <= '0;
          end
        end
      endcase
    end
  end

  assign outclk    = r_clk;
  assign outclk_en = r_pen;
  assign locked    = r_locked;
  assign cfg_ready = r_ready;

`ifdef CLKGEN_SYNC_PULSE_EN
  logic r_sync;
  logic w_all_zero;

  always_comb begin
    w_all_zero = 1'b1;
    for (int i = 0; i < NUM_CLOCKS; i++)
      if (w_en_nxt[i] && (w_cnt_nxt[i] != '0))
        w_all_zero = 1'b0;
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst)
      r_sync <= 1'b0;
    else
      r_sync <= w_lock_nxt && (|w_en_nxt) && w_all_zero;
  end

  assign sync_pulse = r_sync;
`endif

endmodule

// File: tb/tb_qsys_clkdiv_multi.sv
// Bench for qsys_clkdiv_multi: fixed vectors, directed corner sequences, and random reconfiguration
// checked every cycle against an arithmetic model (count = (phase + cycles since restart) mod D).
module tb_qsys_clkdiv_multi;
  localparam int NC = 4;
  localparam int DW = 16;
  localparam int L  = 16;

  logic          refclk = 1'b0;
  logic          rst;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [2:0]    cfg_chan;
  logic [DW-1:0] cfg_div;
  logic [DW-1:0] cfg_phase;
  logic [NC-1:0] outclk;
  logic [NC-1:0] outclk_en;
  logic          locked;
`ifdef CLKGEN_SYNC_PULSE_EN
  logic          sync_pulse;
`endif

  qsys_clkdiv_multi #(
    .NUM_CLOCKS(NC), .DIV_W(DW), .DEFAULT_DIV(4), .LOCK_CYCLES(L)
  ) dut (
    .refclk(refclk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_chan(cfg_chan), .cfg_div(cfg_div), .cfg_phase(cfg_phase),
    .outclk(outclk), .outclk_en(outclk_en),
`ifdef CLKGEN_SYNC_PULSE_EN
    .sync_pulse(sync_pulse),
`endif
    .locked(locked)
  );

  always #5 refclk = ~refclk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: per-channel divisor/phase, cycles since last restart, and a "just reset" flag.
  int md [NC];
  int mp [NC];
  int m_el;
  bit m_rst;

  typedef struct {
    int           n;
    logic [NC-1:0] clk;
    logic [NC-1:0] en;
    logic          lk;
  } vec_t;
  vec_t tbl [8];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
  endtask

  function automatic bit m_locked();
    return !m_rst && (m_el >= L);
  endfunction

  function automatic int m_cnt(input int i);
    return (mp[i] + m_el) % md[i];
  endfunction

  function automatic logic [NC-1:0] m_clk();
    logic [NC-1:0] r = '0;
    for (int i = 0; i < NC; i++)
      if (!m_rst && md[i] >= 2) r[i] = (m_cnt(i) < md[i] / 2);
    return r;
  endfunction

  function automatic logic [NC-1:0] m_en();
    logic [NC-1:0] r = '0;
    for (int i = 0; i < NC; i++)
      if (!m_rst && md[i] >= 2) r[i] = (m_cnt(i) == 0);
    return r;
  endfunction

  function automatic bit m_sync();
    bit any = 0;
    bit ok  = 1;
    if (!m_locked()) return 0;
    for (int i = 0; i < NC; i++)
      if (md[i] >= 2) begin
        any = 1;
        if (m_cnt(i) != 0) ok = 0;
      end
    return any && ok;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NC; i++) begin
      md[i] = 4;
      mp[i] = 0;
    end
    m_el  = 0;
    m_rst = 1;
  endtask

  task automatic model_edge();
    if (cfg_valid && m_locked() && int'(cfg_chan) < NC) begin
      md[cfg_chan] = int'(cfg_div);
      mp[cfg_chan] = (cfg_phase >= cfg_div) ? 0 : int'(cfg_phase);
      m_el = 0;
    end else begin
      m_el++;
    end
    m_rst = 0;
  endtask

  task automatic compare_all();
    check("outclk", outclk, m_clk());
    check("outclk_en", outclk_en, m_en());
    check("locked", locked, m_locked());
    check("cfg_ready", cfg_ready, m_locked());
`ifdef CLKGEN_SYNC_PULSE_EN
    check("sync_pulse", sync_pulse, m_sync());
`endif
  endtask

  task automatic tick();
    @(posedge refclk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic apply_reset();
    #2;
    cfg_valid = 1'b0;
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_outclk", outclk, 0);
    check("rst_outclk_en", outclk_en, 0);
    check("rst_locked", locked, 0);
    check("rst_cfg_ready", cfg_ready, 0);
`ifdef CLKGEN_SYNC_PULSE_EN
    check("rst_sync", sync_pulse, 0);
`endif
    @(posedge refclk);
    @(posedge refclk);
    #1;
    rst = 1'b0;
  endtask

  task automatic do_cfg(input int ch, input int dv, input int ph);
    bit acc = 0;
    bit a;
    cfg_chan  = 3'(ch);
    cfg_div   = DW'(dv);
    cfg_phase = DW'(ph);
    cfg_valid = 1'b1;
    for (int k = 0; k < 64; k++) begin
      a = cfg_ready;
      tick();
      if (a) begin
        acc = 1;
        break;
      end
    end
    cfg_valid = 1'b0;
    if (!acc) check("cfg_timeout", 0, 1);
  endtask

  task automatic wait_lock();
    bit ok = 0;
    for (int k = 0; k < 64; k++) begin
      if (locked) begin
        ok = 1;
        break;
      end
      tick();
    end
    if (!ok) check("lock_timeout", 0, 1);
  endtask

  initial begin
    logic [4:0] v5;
    logic [5:0] v6;
    logic       seen;
    int         e;
    int         pulses;

    tbl[0] = '{1,  4'hF, 4'h0, 1'b0};
    tbl[1] = '{2,  4'h0, 4'h0, 1'b0};
    tbl[2] = '{3,  4'h0, 4'h0, 1'b0};
    tbl[3] = '{4,  4'hF, 4'hF, 1'b0};
    tbl[4] = '{5,  4'hF, 4'h0, 1'b0};
    tbl[5] = '{15, 4'h0, 4'h0, 1'b0};
    tbl[6] = '{16, 4'hF, 4'hF, 1'b1};
    tbl[7] = '{17, 4'hF, 4'h0, 1'b1};

    rst = 1'b0; cfg_valid = 1'b0; cfg_chan = '0; cfg_div = '0; cfg_phase = '0;
    apply_reset();

    // Default D=4 pattern and lock timing
    e = 0;
    for (int t = 0; t < 8; t++) begin
      while (e < tbl[t].n) begin
        tick();
        e++;
      end
      check("t1_outclk", outclk, tbl[t].clk);
      check("t1_outclk_en", outclk_en, tbl[t].en);
      check("t1_locked", locked, tbl[t].lk);
    end

    // Channel 1: D=5, P=2
    do_cfg(1, 5, 2);
    check("t2_locked_drop", locked, 0);
    check("t2_ready_drop", cfg_ready, 0);
    check("t2_outclk_restart", outclk, 4'b1101);
    check("t2_en_restart", outclk_en, 4'b1101);
    v5 = {4'b0, outclk[1]};
    for (int k = 0; k < 4; k++) begin
      tick();
      v5 = {v5[3:0], outclk[1]};
    end
    check("t2_ch1_seq", v5, 5'b00011);
    repeat (11) tick();
    check("t2_prelock", locked, 0);
    tick();
    check("t2_relock", locked, 1);

    // Channel 2 disabled with D=1
    do_cfg(2, 1, 0);
    seen = outclk[2] | outclk_en[2];
    for (int k = 0; k < 20; k++) begin
      tick();
      seen = seen | outclk[2] | outclk_en[2];
    end
    check("t3_ch2_quiet", seen, 0);

    // Channel 3: phase clamp, then out-of-range channel
    wait_lock();
    do_cfg(3, 6, 9);
    v6 = {5'b0, outclk[3]};
    for (int k = 0; k < 5; k++) begin
      tick();
      v6 = {v6[4:0], outclk[3]};
    end
    check("t4_ch3_seq", v6, 6'b111000);
    wait_lock();
    do_cfg(7, 3, 0);
    check("t4_badchan_locked", locked, 1);
    check("t4_badchan_ready", cfg_ready, 1);

    // Reset in the middle of SETTLE
    do_cfg(0, 3, 1);
    repeat (5) tick();
    apply_reset();
    repeat (4) tick();
    check("t5_en_all", outclk_en, 4'hF);
    check("t5_clk_all", outclk, 4'hF);
    wait_lock();

    // Random reconfiguration, including requests issued during SETTLE
    for (int r = 0; r < 30; r++) begin
      repeat ($urandom_range(0, 3)) tick();
      do_cfg(int'($urandom_range(0, 7)), int'($urandom_range(0, 12)), int'($urandom_range(0, 15)));
    end
    wait_lock();

`ifdef CLKGEN_SYNC_PULSE_EN
    apply_reset();
    wait_lock();
    do_cfg(0, 4, 0);
    do_cfg(1, 6, 0);
    do_cfg(2, 0, 0);
    do_cfg(3, 0, 0);
    wait_lock();
    pulses = 0;
    for (int k = 0; k < 48; k++) begin
      tick();
      check("t6_sync_align", sync_pulse, outclk_en[0] & outclk_en[1]);
      pulses += int'(sync_pulse);
    end
    check("t6_pulse_count", pulses, 4);
`else
    pulses = 0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
